// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, lane layout, latched request record.
// Lane 0 is the most significant byte (bits 31:24), so a lanes_t packs straight onto a 32-bit word.
// Port ids identify the core port and the loader/debug DMA port.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  localparam int LANES = 4;

  typedef logic [1:0]              lane_idx_t;
  typedef logic [0:LANES-1][7:0]   lanes_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic        is_byte;
    logic [31:0] wdata;
  } req_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; gnt is combinational from req while en is high.
// Latency: 0 cycles (grant in the request cycle); pointer moves on the handshake edge.
// Backpressure: an ungranted request simply stays pending; gnt is never two-hot.
// Ports: clk/rst, en (arbiter may grant), req[1:0] valids, gnt[1:0] one-hot-or-zero grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // last_q holds the port served most recently; reset to 1 so port 0 wins the first tie.
  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // gnt only ever rises with its req, so any grant is a handshake.
  always_comb begin
    last_d = last_q;
    if (|gnt) begin
      last_d = gnt[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one word-wide byte-lane data memory between the core port (0) and the DMA port (1).
// Latency from handshake T: word load T+L+1, word store T+2, byte store T+L+2, byte load T+L+1.
// Backpressure: one transaction in flight; ready only in IDLE, to a single round-robin winner.
// Ports: reqN_* valid/ready request channels with done/rdata completion, mem_* word memory side.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_addr,
  input  logic            req0_we,
  input  logic            req0_byte,
  input  logic [XLEN-1:0] req0_wdata,
  output logic            req0_done,
  output logic [XLEN-1:0] req0_rdata,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_addr,
  input  logic            req1_we,
  input  logic            req1_byte,
  input  logic [XLEN-1:0] req1_wdata,
  output logic            req1_done,
  output logic [XLEN-1:0] req1_rdata,
  output logic [XLEN-1:0] mem_addr,
  output lanes_t          mem_data_in,
  input  lanes_t          mem_data_out,
  output logic            mem_write_en
);

  localparam logic [1:0] CNT_LAST = 2'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  req_t        req0_in, req1_in;
  logic        port_q, port_d;
  lanes_t      word_q, word_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  lanes_t      din_q, din_d;
  logic        wen_q, wen_d;
  logic [1:0]  done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  gnt;
  logic        idle;

  assign idle    = (state_q == IDLE);
  assign req0_in = '{addr: req0_addr, we: req0_we, is_byte: req0_byte, wdata: req0_wdata};
  assign req1_in = '{addr: req1_addr, we: req1_we, is_byte: req1_byte, wdata: req1_wdata};

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (idle),
    .req ({req1_valid, req0_valid}),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    port_d  = port_q;
    word_d  = word_q;

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          port_d  = gnt[1] ? PORT_DMA : PORT_CORE;
          req_d   = gnt[1] ? req1_in : req0_in;
          cnt_d   = 2'd0;
          // Only whole-word stores can skip the read; byte stores need the old word to merge.
          state_d = (req_d.we && !req_d.is_byte) ? WRITE : READ;
        end
      end
      READ: begin
        if (cnt_q == CNT_LAST) begin
          word_d  = mem_data_out;
          // Word stores never enter READ, so a store here is always a byte store.
          state_d = req_q.we ? WRITE : RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up with the state they belong to.
    mem_addr_d = '0;
    din_d      = '0;
    wen_d      = 1'b0;
    done_d     = 2'b00;
    rdata_d    = '0;

    if (state_d == READ || state_d == WRITE) begin
      mem_addr_d = {req_d.addr[31:2], 2'b00};
    end

    if (state_d == WRITE) begin
      wen_d = 1'b1;
      if (req_d.is_byte) begin
        din_d = word_d;
        din_d[lane_idx_t'(req_d.addr[1:0])] = req_d.wdata[7:0];
      end else begin
        din_d = req_d.wdata;
      end
    end

    if (state_d == RESP) begin
      done_d[port_d] = 1'b1;
      if (!req_d.we) begin
        rdata_d = req_d.is_byte ? sext8(word_d[lane_idx_t'(req_d.addr[1:0])]) : word_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      req_q      <= '0;
      port_q     <= PORT_CORE;
      word_q     <= '0;
      mem_addr_q <= '0;
      din_q      <= '0;
      wen_q      <= 1'b0;
      done_q     <= 2'b00;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      port_q     <= port_d;
      word_q     <= word_d;
      mem_addr_q <= mem_addr_d;
      din_q      <= din_d;
      wen_q      <= wen_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = din_q;
  assign mem_write_en = wen_q;
  assign req0_done    = done_q[0];
  assign req1_done    = done_q[1];
  // Only the owning port sees the result word.
  assign req0_rdata   = done_q[0] ? rdata_q : '0;
  assign req1_rdata   = done_q[1] ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic mem_init;
  always #5 clk = ~clk;

  logic [1:0]  d_valid;
  logic [31:0] d_addr [0:1];
  logic [31:0] d_wdata[0:1];
  logic        d_we   [0:1];
  logic        d_byte [0:1];

  logic a_rdy0, a_rdy1, a_done0, a_done1, a_we;
  logic b_rdy0, b_rdy1, b_done0, b_done1, b_we;
  logic [31:0] a_rd0, a_rd1, a_maddr, a_din, a_dout;
  logic [31:0] b_rd0, b_rd1, b_maddr, b_din, b_dout;

  dmem_arbiter #(.MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(d_valid[0] & ~sel), .req0_ready(a_rdy0), .req0_addr(d_addr[0]), .req0_we(d_we[0]),
    .req0_byte(d_byte[0]), .req0_wdata(d_wdata[0]), .req0_done(a_done0), .req0_rdata(a_rd0),
    .req1_valid(d_valid[1] & ~sel), .req1_ready(a_rdy1), .req1_addr(d_addr[1]), .req1_we(d_we[1]),
    .req1_byte(d_byte[1]), .req1_wdata(d_wdata[1]), .req1_done(a_done1), .req1_rdata(a_rd1),
    .mem_addr(a_maddr), .mem_data_in(a_din), .mem_data_out(a_dout), .mem_write_en(a_we)
  );

  dmem_arbiter #(.MEM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(d_valid[0] & sel), .req0_ready(b_rdy0), .req0_addr(d_addr[0]), .req0_we(d_we[0]),
    .req0_byte(d_byte[0]), .req0_wdata(d_wdata[0]), .req0_done(b_done0), .req0_rdata(b_rd0),
    .req1_valid(d_valid[1] & sel), .req1_ready(b_rdy1), .req1_addr(d_addr[1]), .req1_we(d_we[1]),
    .req1_byte(d_byte[1]), .req1_wdata(d_wdata[1]), .req1_done(b_done1), .req1_rdata(b_rd1),
    .mem_addr(b_maddr), .mem_data_in(b_din), .mem_data_out(b_dout), .mem_write_en(b_we)
  );

  // Memory models: L=1 reads combinationally, L=3 adds two register stages after the read.
  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];
  logic [31:0] b_p1, b_p2;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
      mem_a[16] <= 32'h11223344;
      mem_a[18] <= 32'hCAFEF00D;
      mem_b[16] <= 32'h11223380;
      mem_b[17] <= 32'h1122337F;
    end else begin
      if (a_we) mem_a[a_maddr[7:2]] <= a_din;
      if (b_we) mem_b[b_maddr[7:2]] <= b_din;
    end
    b_p1 <= mem_b[b_maddr[7:2]];
    b_p2 <= b_p1;
  end
  assign a_dout = mem_a[a_maddr[7:2]];
  assign b_dout = b_p2;

  logic [1:0]  cur_rdy, cur_done;
  logic [31:0] cur_rd0, cur_rd1, cur_maddr, cur_din;
  logic        cur_we;
  assign cur_rdy   = sel ? {b_rdy1, b_rdy0} : {a_rdy1, a_rdy0};
  assign cur_done  = sel ? {b_done1, b_done0} : {a_done1, a_done0};
  assign cur_rd0   = sel ? b_rd0 : a_rd0;
  assign cur_rd1   = sel ? b_rd1 : a_rd1;
  assign cur_maddr = sel ? b_maddr : a_maddr;
  assign cur_din   = sel ? b_din : a_din;
  assign cur_we    = sel ? b_we : a_we;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        p;
    logic        we;
    logic        bt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_wr_k;
    logic [31:0] exp_word;
    int          exp_done_k;
  } vec_t;

  function automatic vec_t mk(input logic p, input logic we, input logic bt, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata, input int exp_wr_k,
                              input logic [31:0] exp_word, input int exp_done_k);
    vec_t v;
    v.p = p; v.we = we; v.bt = bt; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
    v.exp_wr_k = exp_wr_k; v.exp_word = exp_word; v.exp_done_k = exp_done_k;
    return v;
  endfunction

  // One transaction; k counts cycles after the handshake cycle T.
  task automatic run(input vec_t v);
    int done_k, done_n, oth_n, wr_n, wr_k;
    logic [31:0] rd, wr_word, wr_addr;
    bit got;
    done_k = -1; done_n = 0; oth_n = 0; wr_n = 0; wr_k = -1;
    rd = '0; wr_word = '0; wr_addr = '0; got = 1'b0;
    @(negedge clk);
    d_addr[v.p] = v.addr; d_we[v.p] = v.we; d_byte[v.p] = v.bt; d_wdata[v.p] = v.wdata;
    d_valid[v.p] = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (cur_rdy[v.p]) got = 1'b1;
      else @(negedge clk);
    end
    chk("grant", 32'(got), 32'd1);
    if (!got) begin
      d_valid = 2'b00;
      return;
    end
    @(posedge clk);
    #1 d_valid[v.p] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (cur_we) begin
        wr_n++; wr_k = k; wr_word = cur_din; wr_addr = cur_maddr;
      end
      if (cur_done[v.p]) begin
        done_n++; done_k = k; rd = v.p ? cur_rd1 : cur_rd0;
      end
      if (cur_done[~v.p]) oth_n++;
    end
    chk("done_cycle", done_k, v.exp_done_k);
    chk("done_pulses", done_n, 32'd1);
    chk("other_port_done", oth_n, 32'd0);
    chk("rdata", rd, v.exp_rdata);
    chk("write_count", wr_n, 32'(v.we));
    if (v.we) begin
      chk("write_cycle", wr_k, v.exp_wr_k);
      chk("write_lanes", wr_word, v.exp_word);
      chk("write_addr", wr_addr, {v.addr[31:2], 2'b00});
    end
  endtask

  vec_t tab_a[$];
  vec_t tab_b[$];

  initial begin
    int order_i;
    int wr_n, done_n;
    bit got;

    // L=1 vectors: latency columns are cycles after the handshake cycle.
    tab_a.push_back(mk(0, 0, 0, 32'h40, 32'h0,        32'h11223344, 0, 32'h0,        2));
    tab_a.push_back(mk(1, 1, 1, 32'h42, 32'hAB,       32'h0,        2, 32'h1122AB44, 3));
    tab_a.push_back(mk(0, 0, 0, 32'h40, 32'h0,        32'h1122AB44, 0, 32'h0,        2));
    tab_a.push_back(mk(0, 1, 0, 32'h40, 32'h11223380, 32'h0,        1, 32'h11223380, 2));
    tab_a.push_back(mk(1, 0, 1, 32'h43, 32'h0,        32'hFFFFFF80, 0, 32'h0,        2));
    tab_a.push_back(mk(0, 1, 1, 32'h43, 32'hFFFFFF7F, 32'h0,        2, 32'h1122337F, 3));
    tab_a.push_back(mk(0, 0, 1, 32'h43, 32'h0,        32'h0000007F, 0, 32'h0,        2));
    tab_a.push_back(mk(0, 1, 0, 32'h10, 32'hDEADBEEF, 32'h0,        1, 32'hDEADBEEF, 2));
    tab_a.push_back(mk(1, 0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 32'h0,        2));
    tab_a.push_back(mk(0, 0, 0, 32'h13, 32'h0,        32'hDEADBEEF, 0, 32'h0,        2));
    tab_a.push_back(mk(1, 0, 1, 32'h11, 32'h0,        32'hFFFFFFAD, 0, 32'h0,        2));
    tab_a.push_back(mk(0, 0, 1, 32'h40, 32'h0,        32'h00000011, 0, 32'h0,        2));
    tab_a.push_back(mk(1, 1, 0, 32'h2E, 32'h01020304, 32'h0,        1, 32'h01020304, 2));
    // L=3 vectors.
    tab_b.push_back(mk(0, 0, 1, 32'h43, 32'h0,        32'hFFFFFF80, 0, 32'h0,        4));
    tab_b.push_back(mk(1, 0, 1, 32'h47, 32'h0,        32'h0000007F, 0, 32'h0,        4));
    tab_b.push_back(mk(0, 0, 0, 32'h40, 32'h0,        32'h11223380, 0, 32'h0,        4));
    tab_b.push_back(mk(1, 1, 1, 32'h46, 32'h99,       32'h0,        4, 32'h1122997F, 5));
    tab_b.push_back(mk(0, 0, 0, 32'h44, 32'h0,        32'h1122997F, 0, 32'h0,        4));
    tab_b.push_back(mk(0, 1, 0, 32'h44, 32'hCAFEBABE, 32'h0,        1, 32'hCAFEBABE, 2));

    rst = 1'b1; sel = 1'b0; mem_init = 1'b1; d_valid = 2'b00;
    for (int p = 0; p < 2; p++) begin
      d_addr[p] = '0; d_wdata[p] = '0; d_we[p] = 1'b0; d_byte[p] = 1'b0;
    end

    #1;
    chk("rst_ready", {30'd0, a_rdy1, a_rdy0}, 32'd0);
    chk("rst_done", {30'd0, a_done1, a_done0}, 32'd0);
    chk("rst_rdata", a_rd0 | a_rd1, 32'd0);
    chk("rst_mem_addr", a_maddr, 32'd0);
    chk("rst_mem_data_in", a_din, 32'd0);
    chk("rst_write_en", 32'(a_we), 32'd0);

    // Both ports pending at reset exit: grants must go 0,1,0,1.
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    d_addr[0] = 32'h40; d_addr[1] = 32'h10;
    d_valid = 2'b11;
    rst = 1'b0;
    order_i = 0;
    for (int c = 0; c < 80 && order_i < 4; c++) begin
      #1;
      if (a_rdy0 && a_rdy1) chk("dual_grant", 32'd3, 32'd1);
      if (a_rdy0 || a_rdy1) begin
        chk("rr_order", 32'(a_rdy1), 32'(order_i % 2));
        order_i++;
        @(posedge clk);
      end
      @(negedge clk);
    end
    chk("rr_grants", order_i, 32'd4);
    d_valid = 2'b00;
    repeat (6) @(negedge clk);

    foreach (tab_a[i]) run(tab_a[i]);

    // Reset during the READ of a byte store: no write, no done, back to normal afterwards.
    @(negedge clk);
    d_addr[1] = 32'h48; d_we[1] = 1'b1; d_byte[1] = 1'b1; d_wdata[1] = 32'h55;
    d_valid[1] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (a_rdy1) got = 1'b1;
      else @(negedge clk);
    end
    chk("rst_case_grant", 32'(got), 32'd1);
    @(posedge clk);
    #1 d_valid[1] = 1'b0;
    rst = 1'b1;
    wr_n = 0; done_n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b0;
      if (a_we) wr_n++;
      if (a_done0 || a_done1) done_n++;
    end
    chk("abort_writes", wr_n, 32'd0);
    chk("abort_done", done_n, 32'd0);
    chk("abort_mem_addr", a_maddr, 32'd0);
    chk("abort_mem_word", mem_a[18], 32'hCAFEF00D);
    run(mk(1, 1, 1, 32'h48, 32'h55, 32'h0, 2, 32'h55FEF00D, 3));

    sel = 1'b1;
    foreach (tab_b[i]) run(tab_b[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single byte-lane data memory (4 x 8-bit lanes, lane 0 = bits 31:24) between two requesters: port 0 is the core data port and port 1 is the loader/debug DMA port. Round-robin arbitration with one transaction outstanding at a time. Byte stores are sequenced as read-modify-write so the memory sees only whole-word writes. Byte loads return a sign-extended result.

Parameters:
MEM_LATENCY, 1, cycles from mem_addr stable to mem_data_out valid; legal range 1..4.
XLEN, 32, data/address width; fixed at 32.

Ports:
clk  in  1  clock, all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
reqN_valid  in  1  request from port N (N = 0, 1).
reqN_ready  out  1  grant; the transfer is accepted when valid and ready are both high.
reqN_addr  in  32  byte address.
reqN_we  in  1  1 = store, 0 = load.
reqN_byte  in  1  1 = byte access (LB/SB), 0 = word access.
reqN_wdata  in  32  store data; for byte stores the byte is wdata[7:0].
reqN_done  out  1  one-cycle completion pulse (loads and stores).
reqN_rdata  out  32  load result; valid only while reqN_done is high.
mem_addr  out  32  word-aligned memory address {addr[31:2],2'b00}.
mem_data_in  out  4x8  write lanes.
mem_data_out  in  4x8  read lanes.
mem_write_en  out  1  whole-word write strobe.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE and the RR pointer is set so port 0 wins the first tie.
  - Outputs: all ready=0, done=0, rdata=0, mem_addr=0, mem_data_in=0, mem_write_en=0.
  - Reset during any state aborts the transaction: no write is issued and no done pulse.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - ready is asserted combinationally to the winning valid requester only; it is never asserted to both ports at once.
  - Only one request valid: that request is granted.
  - Both requests valid: grant the port not served last; the pointer updates on each handshake.
  - On handshake, latch addr, we, byte, wdata and port id.
  - Next state: READ if load or byte store; WRITE if word store.
- READ:
  - Drives mem_addr for MEM_LATENCY cycles (counter).
  - At the last cycle, captures mem_data_out into an internal word register.
  - Next state: WRITE if byte store, else RESP.
- WRITE:
  - One cycle with mem_write_en=1 and mem_addr driven.
  - Word store: lanes = wdata[31:24], [23:16], [15:8], [7:0] on lanes 0..3.
  - Byte store: lane addr[1:0] = wdata[7:0]; other lanes = the captured read word.
  - Next state: RESP.
- RESP:
  - Registered done=1 to the owning port for exactly one cycle.
  - rdata: word load = {lane0,lane1,lane2,lane3}; byte load = sign-extend(lane addr[1:0]); stores = 0.
  - Next state: IDLE; no request is accepted in RESP.
- Latency from the handshake cycle T:
  - Word load: done at T+L+1.
  - Word store: write at T+1, done at T+2.
  - Byte store: write at T+L+1, done at T+L+2.
  - Byte load: done at T+L+1.
- Word access with addr[1:0] != 0: the low bits are ignored (aligned access); no error.
- While not in READ or WRITE: mem_addr=0 and mem_data_in=0, so the memory never sees a spurious write.
- A requester dropping valid before the handshake is legal; a request that is not granted stays pending without loss.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (IDLE/READ/WRITE/RESP).
  - LANES=4 and lane index type.
  - req_t struct (addr, we, byte, wdata).
  - Port id constants PORT_CORE=0 and PORT_DMA=1.
- Sub-module rr_arbiter2: a 2-input round-robin grant with a pointer that updates on accept.
- Lane merge and sign-extension stay inline.

Test Plan:
1. L=1; memory word at 0x40 = 0x11223344; req0 word load 0x40 -> req0_done at T+2 with rdata 0x11223344; req1 idle.
2. req0 and req1 both valid at reset exit -> req0 granted first, req1 granted on the next IDLE; repeat with both still valid -> order alternates 0,1,0,1.
3. Byte store from req1: addr 0x42, wdata 0xAB, memory holding 0x11223344 -> exactly one mem_write_en cycle at T+L+1 with lanes {11,22,AB,44}; done at T+L+2.
4. Byte load addr 0x43 where lane 3 = 0x80 -> rdata 0xFFFFFF80; lane 3 = 0x7F -> 0x0000007F; repeat with MEM_LATENCY=3 -> done at T+4.
5. Assert rst during the READ of a byte store -> mem_write_en never rises, no done pulse, state IDLE; the next request completes normally.
6. Word store req0 to 0x10 with wdata 0xDEADBEEF -> write at T+1 with lanes {DE,AD,BE,EF}; the following word load returns 0xDEADBEEF.
